// File: rtl/vc_pop_arbiter_pkg.sv
// Shared constants for the VC pop arbiter, the VC FIFOs and the destination FIFOs.
package vc_pop_arbiter_pkg;

  localparam int VC_DATA_W   = 10;
  localparam int VC_DEST_LSB = 8;
  localparam int NUM_DEST    = 4;
  localparam int DEST_W      = 2;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
    logic [NUM_DEST-1:0] oh;
    oh       = '0;
    oh[dest] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// VC FIFO pop side and destination FIFO push side of the arbiter, bundled.
interface vc_pop_arbiter_if
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_W = VC_DATA_W
);

  logic                vc0_empty;
  logic                vc1_empty;
  logic [DATA_W-1:0]   vc0_data;
  logic [DATA_W-1:0]   vc1_data;
  logic                vc0_pop;
  logic                vc1_pop;
  logic [NUM_DEST-1:0] d_almost_full;
  logic [NUM_DEST-1:0] d_push;
  logic [DATA_W-1:0]   d_data;

  // Arbiter side: consumes FIFO status, produces pops and pushes.
  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data, d_almost_full,
    output vc0_pop, vc1_pop, d_push, d_data
  );

  // FIFO side: produces status and data, consumes pops and pushes.
  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data, d_almost_full,
    input  vc0_pop, vc1_pop, d_push, d_data
  );

endinterface

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 with strict VC0 priority and routes each word to one of four
// destination FIFOs by its 2-bit dest field; counts words per destination.
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_W   = VC_DATA_W,
  parameter int DEST_LSB = VC_DEST_LSB,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  vc_pop_arbiter_if.master bus,
  output logic             idle,
  output logic [CNT_W-1:0] cnt_d0,
  output logic [CNT_W-1:0] cnt_d1,
  output logic [CNT_W-1:0] cnt_d2,
  output logic [CNT_W-1:0] cnt_d3
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                stall;
  logic                pop0;
  logic                pop1;
  logic                rd_vld;
  logic                rd_sel;
  logic [DATA_W-1:0]   rd_word;
  logic [DEST_W-1:0]   rd_dest;
  logic [DATA_W-1:0]   d_data_q;
  logic [NUM_DEST-1:0] d_push_q;
  logic [CNT_W-1:0]    cnt [NUM_DEST];

  // Strict-priority pop decision; any almost_full blocks both VCs, reset blocks pops.
  always_comb begin
    stall = |bus.d_almost_full;
    pop0  = reset_L & ~stall & ~bus.vc0_empty;
    pop1  = reset_L & ~stall & bus.vc0_empty & ~bus.vc1_empty;
  end

  assign bus.vc0_pop = pop0;
  assign bus.vc1_pop = pop1;

  // Read stage: remember that a word is arriving next cycle and from which VC.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_vld <= 1'b0;
      rd_sel <= VC0;
    end else begin
      rd_vld <= pop0 | pop1;
      rd_sel <= pop1 ? VC1 : VC0;
    end
  end

  assign rd_word = (rd_sel == VC1) ? bus.vc1_data : bus.vc0_data;
  assign rd_dest = rd_word[DEST_LSB+1:DEST_LSB];

  // Push stage: register the word, its one-hot push strobe and bump its counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d_push_q <= '0;
      d_data_q <= '0;
      for (int i = 0; i < NUM_DEST; i++) begin
        cnt[i] <= '0;
      end
    end else if (rd_vld) begin
      d_push_q     <= dest_onehot(rd_dest);
      d_data_q     <= rd_word;
      cnt[rd_dest] <= cnt[rd_dest] + CNT_ONE;
    end else begin
      d_push_q <= '0;
    end
  end

  assign bus.d_push = d_push_q;
  assign bus.d_data = d_data_q;

  assign idle = bus.vc0_empty & bus.vc1_empty & ~rd_vld & (d_push_q == '0);

  assign cnt_d0 = cnt[0];
  assign cnt_d1 = cnt[1];
  assign cnt_d2 = cnt[2];
  assign cnt_d3 = cnt[3];

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter: a table of arbitration vectors plus
// hand-written multi-cycle sequences with queue-based VC FIFO models.
module tb_vc_pop_arbiter;
  import vc_pop_arbiter_pkg::*;

  localparam int DW = 10;
  localparam int CW = 8;

  typedef struct {
    logic       v0e;
    logic       v1e;
    logic [3:0] af;
    logic       p0;
    logic       p1;
    logic       idl;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          idle;
  logic [CW-1:0] cnt_d0;
  logic [CW-1:0] cnt_d1;
  logic [CW-1:0] cnt_d2;
  logic [CW-1:0] cnt_d3;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_cnt [4];
  logic [DW-1:0] vc0_q [$];
  logic [DW-1:0] vc1_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  vec_t          vecs [9];

  vc_pop_arbiter_if #(.DATA_W(DW)) bus ();

  vc_pop_arbiter #(.DATA_W(DW), .DEST_LSB(8), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.master),
    .idle    (idle),
    .cnt_d0  (cnt_d0),
    .cnt_d1  (cnt_d1),
    .cnt_d2  (cnt_d2),
    .cnt_d3  (cnt_d3)
  );

  always #5 clk = ~clk;

  // VC FIFO read ports: data_out presents the popped word the cycle after the pop.
  always @(posedge clk) begin
    if (bus.vc0_pop && vc0_q.size() > 0) bus.vc0_data <= vc0_q.pop_front();
    if (bus.vc1_pop && vc1_q.size() > 0) bus.vc1_data <= vc1_q.pop_front();
  end

  // Destination side: log every pushed word and check the strobe matches its dest field.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && bus.d_push !== 4'b0000) begin
      got_q.push_back(bus.d_data);
      checkOutput("push_onehot", 32'(bus.d_push), 32'(4'b0001 << bus.d_data[9:8]));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.vc0_empty = (vc0_q.size() == 0);
    bus.vc1_empty = (vc1_q.size() == 0);
    #1;
  endtask

  task automatic load0(input logic [DW-1:0] w);
    vc0_q.push_back(w);
    bus.vc0_empty = 1'b0;
  endtask

  task automatic load1(input logic [DW-1:0] w);
    vc1_q.push_back(w);
    bus.vc1_empty = 1'b0;
  endtask

  task automatic expectWord(input logic [DW-1:0] w);
    exp_q.push_back(w);
    exp_cnt[int'(w[9:8])]++;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    step();
    bus.vc0_empty     = v.v0e;
    bus.vc1_empty     = v.v1e;
    bus.d_almost_full = v.af;
    #1;
    checkOutput($sformatf("vec%0d_vc0_pop", idx), 32'(bus.vc0_pop), 32'(v.p0));
    checkOutput($sformatf("vec%0d_vc1_pop", idx), 32'(bus.vc1_pop), 32'(v.p1));
    checkOutput($sformatf("vec%0d_idle", idx), 32'(idle), 32'(v.idl));
    bus.vc0_empty     = 1'b1;
    bus.vc1_empty     = 1'b1;
    bus.d_almost_full = 4'b0000;
    #1;
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_cnt_d0"}, 32'(cnt_d0), exp_cnt[0] & 32'hFF);
    checkOutput({name, "_cnt_d1"}, 32'(cnt_d1), exp_cnt[1] & 32'hFF);
    checkOutput({name, "_cnt_d2"}, 32'(cnt_d2), exp_cnt[2] & 32'hFF);
    checkOutput({name, "_cnt_d3"}, 32'(cnt_d3), exp_cnt[3] & 32'hFF);
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      checkOutput({name, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (idle !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checkOutput("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic checkPops(input string name, input logic p0, input logic p1);
    checkOutput({name, "_vc0_pop"}, 32'(bus.vc0_pop), 32'(p0));
    checkOutput({name, "_vc1_pop"}, 32'(bus.vc1_pop), 32'(p1));
  endtask

  // Main directed sequence.
  initial begin
    reset_L           = 1'b0;
    bus.vc0_empty     = 1'b1;
    bus.vc1_empty     = 1'b1;
    bus.d_almost_full = 4'b0000;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

    vecs[0] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};

    $display("[TB] reset state");
    step();
    step();
    checkPops("rst", 1'b0, 1'b0);
    checkOutput("rst_d_push", 32'(bus.d_push), 32'd0);
    checkOutput("rst_d_data", 32'(bus.d_data), 32'd0);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    checkCounters("rst");
    bus.vc0_empty = 1'b0;
    bus.vc1_empty = 1'b0;
    #1;
    checkPops("rst_forced", 1'b0, 1'b0);
    bus.vc0_empty = 1'b1;
    bus.vc1_empty = 1'b1;
    step();
    reset_L = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkPops("post_rst", 1'b0, 1'b0);
      checkOutput("post_rst_d_push", 32'(bus.d_push), 32'd0);
    end

    $display("[TB] arbitration table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    $display("[TB] two VC0 words");
    step();
    load0(10'h1A5);
    load0(10'h2C3);
    expectWord(10'h1A5);
    expectWord(10'h2C3);
    #1;
    checkPops("two_c0", 1'b1, 1'b0);
    checkOutput("two_c0_d_push", 32'(bus.d_push), 32'd0);
    step();
    checkPops("two_c1", 1'b1, 1'b0);
    checkOutput("two_c1_d_push", 32'(bus.d_push), 32'd0);
    checkOutput("two_c1_idle", 32'(idle), 32'd0);
    step();
    checkPops("two_c2", 1'b0, 1'b0);
    checkOutput("two_c2_d_push", 32'(bus.d_push), 32'b0010);
    checkOutput("two_c2_d_data", 32'(bus.d_data), 32'h1A5);
    checkOutput("two_c2_cnt_d1", 32'(cnt_d1), 32'd1);
    checkOutput("two_c2_idle", 32'(idle), 32'd0);
    step();
    checkOutput("two_c3_d_push", 32'(bus.d_push), 32'b0100);
    checkOutput("two_c3_d_data", 32'(bus.d_data), 32'h2C3);
    checkOutput("two_c3_cnt_d2", 32'(cnt_d2), 32'd1);
    checkOutput("two_c3_idle", 32'(idle), 32'd0);
    step();
    checkOutput("two_c4_d_push", 32'(bus.d_push), 32'd0);
    checkOutput("two_c4_d_data_hold", 32'(bus.d_data), 32'h2C3);
    checkOutput("two_c4_idle", 32'(idle), 32'd1);
    checkLog("two");
    checkCounters("two");

    $display("[TB] VC0 priority over VC1");
    step();
    load0(10'h011);
    load0(10'h122);
    load0(10'h233);
    load1(10'h344);
    load1(10'h055);
    expectWord(10'h011);
    expectWord(10'h122);
    expectWord(10'h233);
    expectWord(10'h344);
    expectWord(10'h055);
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      checkPops($sformatf("prio_c%0d", c), c < 3, (c == 3) || (c == 4));
    end
    waitIdle(20);
    checkLog("prio");
    checkCounters("prio");

    $display("[TB] VC0 preempts a VC1 burst");
    step();
    load1(10'h1B1);
    load1(10'h1B2);
    load1(10'h1B3);
    #1;
    checkPops("pre_c0", 1'b0, 1'b1);
    step();
    load0(10'h0C0);
    #1;
    checkPops("pre_c1", 1'b1, 1'b0);
    step();
    checkPops("pre_c2", 1'b0, 1'b1);
    expectWord(10'h1B1);
    expectWord(10'h0C0);
    expectWord(10'h1B2);
    expectWord(10'h1B3);
    waitIdle(20);
    checkLog("pre");
    checkCounters("pre");

    // Flag rises with one word in the push stage and one in the read stage;
    // both of those still reach the destination, nothing after them does.
    $display("[TB] stall on almost_full");
    step();
    for (int i = 0; i < 8; i++) begin
      load0(10'(i));
      expectWord(10'(i));
    end
    #1;
    step();
    step();
    bus.d_almost_full = 4'b1000;
    #1;
    checkPops("stall_n0", 1'b0, 1'b0);
    checkOutput("stall_n0_d_push", 32'(bus.d_push), 32'b0001);
    checkOutput("stall_n0_d_data", 32'(bus.d_data), 32'h000);
    step();
    checkPops("stall_n1", 1'b0, 1'b0);
    checkOutput("stall_n1_d_push", 32'(bus.d_push), 32'b0001);
    checkOutput("stall_n1_d_data", 32'(bus.d_data), 32'h001);
    step();
    checkPops("stall_n2", 1'b0, 1'b0);
    checkOutput("stall_n2_d_push", 32'(bus.d_push), 32'd0);
    checkOutput("stall_n2_d_data_hold", 32'(bus.d_data), 32'h001);
    step();
    checkPops("stall_n3", 1'b0, 1'b0);
    checkOutput("stall_n3_d_push", 32'(bus.d_push), 32'd0);
    bus.d_almost_full = 4'b0000;
    #1;
    checkPops("stall_release", 1'b1, 1'b0);
    waitIdle(30);
    checkLog("stall");
    checkCounters("stall");

    $display("[TB] reset with a word in flight");
    step();
    load0(10'h3AA);
    #1;
    checkPops("mid_rst_pop", 1'b1, 1'b0);
    step();
    reset_L = 1'b0;
    #1;
    checkOutput("mid_rst_d_push", 32'(bus.d_push), 32'd0);
    checkPops("mid_rst", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    checkCounters("mid_rst");
    step();
    reset_L = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("after_rst_d_push", 32'(bus.d_push), 32'd0);
    end
    checkOutput("after_rst_idle", 32'(idle), 32'd1);
    checkCounters("after_rst");
    checkLog("after_rst");

    $display("[TB] dest 0 counter wrap");
    step();
    for (int i = 0; i < 255; i++) begin
      load0(10'(i & 8'hFF));
      expectWord(10'(i & 8'hFF));
    end
    #1;
    waitIdle(400);
    checkCounters("wrap255");
    checkLog("wrap255");
    step();
    load0(10'h0FF);
    expectWord(10'h0FF);
    #1;
    waitIdle(20);
    checkOutput("wrap256_cnt_d0_zero", 32'(cnt_d0), 32'd0);
    checkCounters("wrap256");
    checkLog("wrap256");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
